// File: rtl/sim_result_pkg.sv
// Shared types and constants for the simulation pass/fail monitor.
package sim_result_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        PASS,
        FAIL
    } sim_result_state_e;

    localparam int unsigned CYC_CNT_W = 16;
    localparam logic [CYC_CNT_W-1:0] CYC_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sim_result_monitor_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sim_result_monitor.sv
// Checks an observed stream against a modular-increment model and raises passed/failed.
// Optional timeout into FAIL is enabled by SIM_RESULT_MONITOR_TIMEOUT_EN.
module sim_result_monitor
    import sim_result_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STEP       = 1,
    parameter int unsigned PASS_COUNT = 16,
    parameter int unsigned MAX_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 obs_valid,
    input  logic [WIDTH-1:0]     obs_value,
    output logic                 passed,
    output logic                 failed,
    output logic [CYC_CNT_W-1:0] cyc_cnt,
    output logic [CYC_CNT_W-1:0] match_cnt
);

    localparam logic [WIDTH-1:0]     STEP_W    = WIDTH'(STEP);
    localparam logic [CYC_CNT_W-1:0] PASS_LAST = CYC_CNT_W'(PASS_COUNT - 1);

    // Elaboration-time guard against unusable configurations.
    if ((PASS_COUNT < 2) || (MAX_CYCLES > 32'(CYC_CNT_MAX))) begin : g_bad_param
        $error("sim_result_monitor: invalid PASS_COUNT or MAX_CYCLES");
    end

    sim_result_state_e state;
    sim_result_state_e state_next;
    logic [WIDTH-1:0]  expected;
    logic [WIDTH-1:0]  expected_next;
    logic              match_en;

    sat_counter #(
        .WIDTH (CYC_CNT_W),
        .MAX   (CYC_CNT_MAX)
    ) u_cyc_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .count   (cyc_cnt)
    );

    // match_cnt is zero in IDLE, so the capture's increment yields 1.
    sat_counter #(
        .WIDTH (CYC_CNT_W),
        .MAX   (CYC_CNT_MAX)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (match_en),
        .count   (match_cnt)
    );

    always_comb begin
        state_next    = state;
        expected_next = expected;
        match_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (obs_valid) begin
                    expected_next = obs_value + STEP_W;
                    match_en      = 1'b1;
                    state_next    = TRACK;
                end
            end
            TRACK: begin
                if (obs_valid) begin
                    if (obs_value == expected) begin
                        expected_next = expected + STEP_W;
                        match_en      = 1'b1;
                        if (match_cnt == PASS_LAST) begin
                            state_next = PASS;
                        end
                    end else begin
                        state_next = FAIL;
                    end
                end
            end
            PASS: ;
            FAIL: ;
            default: state_next = IDLE;
        endcase
`ifdef SIM_RESULT_MONITOR_TIMEOUT_EN
        // A pass decided on the timeout cycle stands.
        if ((cyc_cnt == CYC_CNT_W'(MAX_CYCLES)) &&
            ((state == IDLE) || (state == TRACK)) &&
            (state_next != PASS)) begin
            state_next = FAIL;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            expected <= '0;
            passed   <= 1'b0;
            failed   <= 1'b0;
        end else begin
            state    <= state_next;
            expected <= expected_next;
            passed   <= (state_next == PASS);
            failed   <= (state_next == FAIL);
        end
    end

endmodule

// File: tb/tb_sim_result_monitor.sv
// Directed self-checking bench for sim_result_monitor (WIDTH=8, STEP=1, PASS_COUNT=16).
module tb_sim_result_monitor;

    logic        clk;
    logic        reset_n;
    logic        obs_valid;
    logic [7:0]  obs_value;
    logic        passed;
    logic        failed;
    logic [15:0] cyc_cnt;
    logic [15:0] match_cnt;

    int checks = 0;
    int errors = 0;

    sim_result_monitor #(
        .WIDTH      (8),
        .STEP       (1),
        .PASS_COUNT (16),
        .MAX_CYCLES (100)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .obs_valid (obs_valid),
        .obs_value (obs_value),
        .passed    (passed),
        .failed    (failed),
        .cyc_cnt   (cyc_cnt),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] val);
        obs_valid = v;
        obs_value = v ? val : 8'hxx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        obs_valid = 1'b0;
        obs_value = 8'hxx;
        #2;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic p, input logic f,
                           input logic [15:0] c, input logic [15:0] m);
        chk({tag, ".passed"}, passed, p);
        chk({tag, ".failed"}, failed, f);
        chk({tag, ".cyc_cnt"}, cyc_cnt, c);
        chk({tag, ".match_cnt"}, match_cnt, m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        obs_valid = 1'b0;
        obs_value = 8'h00;
        #3;
        chk_out("reset", 1'b0, 1'b0, 16'd0, 16'd0);

        // Clean count 0..15
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i));
            if (i == 14) chk_out("clean14", 1'b0, 1'b0, 16'd15, 16'd15);
        end
        chk_out("clean_pass", 1'b1, 1'b0, 16'd16, 16'd16);
        step(1'b1, 8'h99);
        chk_out("clean_term", 1'b1, 1'b0, 16'd17, 16'd16);

        // Async reset from a terminal state
        #2 reset_n = 1'b0;
        #1;
        chk_out("term_rst", 1'b0, 1'b0, 16'd0, 16'd0);

        // Wrap-around F8..FF, 00..07
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'hF8 + i));
            if (i == 8) chk_out("wrap00", 1'b0, 1'b0, 16'd9, 16'd9);
        end
        chk_out("wrap_pass", 1'b1, 1'b0, 16'd16, 16'd16);

        // Mismatch 0,1,2,3,5
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i));
        chk_out("mis_pre", 1'b0, 1'b0, 16'd4, 16'd4);
        step(1'b1, 8'd5);
        chk_out("mis_fail", 1'b0, 1'b1, 16'd5, 16'd4);
        for (int i = 6; i < 9; i++) step(1'b1, 8'(i));
        chk_out("mis_term", 1'b0, 1'b1, 16'd8, 16'd4);

        // Gapped samples, one every 10 cycles
        do_reset();
`ifdef SIM_RESULT_MONITOR_TIMEOUT_EN
        for (int s = 0; s < 10; s++) begin
            for (int g = 0; g < 9; g++) step(1'b0, 8'h00);
            step(1'b1, 8'(s));
        end
        chk_out("gap_pre_to", 1'b0, 1'b0, 16'd100, 16'd10);
        step(1'b0, 8'h00);
        chk_out("gap_timeout", 1'b0, 1'b1, 16'd101, 16'd10);
`else
        for (int s = 0; s < 16; s++) begin
            for (int g = 0; g < 9; g++) step(1'b0, 8'h00);
            step(1'b1, 8'(s));
            if (s == 14) chk_out("gap_pre", 1'b0, 1'b0, 16'd150, 16'd15);
        end
        chk_out("gap_pass", 1'b1, 1'b0, 16'd160, 16'd16);
`endif

        // 16th match lands on the timeout cycle
        do_reset();
        for (int g = 0; g < 85; g++) step(1'b0, 8'h00);
        chk_out("same_idle", 1'b0, 1'b0, 16'd85, 16'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        chk_out("same_pass", 1'b1, 1'b0, 16'd101, 16'd16);
        for (int g = 0; g < 3; g++) step(1'b0, 8'h00);
        chk_out("same_hold", 1'b1, 1'b0, 16'd104, 16'd16);

        // Reset mid-TRACK, then restart at 42
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(10 + i));
        chk_out("mid_pre", 1'b0, 1'b0, 16'd7, 16'd7);
        #2 reset_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(42 + i));
            if (i == 14) chk_out("restart14", 1'b0, 1'b0, 16'd15, 16'd15);
        end
        chk_out("restart_pass", 1'b1, 1'b0, 16'd16, 16'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_result_monitor.md
# sim_result_monitor

DUT-side pass/fail generator for the simulation harness: monitors an observed value stream (e.g. the LED counter output), checks it against a modular-increment model and drives the `passed`/`failed` signals that the testbench polls each cycle to end simulation. It sits inside `top` beside the design under test. It also owns the free-running `cyc_cnt` used for timeout and debug dumps.

## Interface
- `WIDTH`, 8: width of the observed value.
- `STEP`, 1: expected increment between consecutive valid samples, applied modulo 2^WIDTH.
- `PASS_COUNT`, 16: number of consecutive correct samples, including the first, that yields a pass. Must be at least 2.
- `MAX_CYCLES`, 100: timeout limit in cycles after reset release. Used only with the timeout feature enabled.
- `clk`  in  1: clock. All state is updated on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `obs_valid`  in  1: `obs_value` is a sample this cycle.
- `obs_value`  in  WIDTH: observed value.
- `passed`  out  1: check succeeded. Sticky.
- `failed`  out  1: mismatch or timeout. Sticky.
- `cyc_cnt`  out  16: cycles since reset release. Saturates at 16'hFFFF.
- `match_cnt`  out  16: consecutive matching samples so far.

## Operation
- State machine with four states: `IDLE`, `TRACK`, `PASS`, `FAIL`.
- Reset values: state = `IDLE`; `passed` = 0; `failed` = 0; `cyc_cnt` = 0; `match_cnt` = 0; internal `expected` = 0.
- **IDLE**, on `obs_valid`:
  - `expected` <= `obs_value` + STEP (truncated to WIDTH).
  - `match_cnt` <= 1.
  - Next state: `TRACK`.
  - The first sample is never checked.
- **TRACK**, on `obs_valid` with `obs_value` == `expected`:
  - `match_cnt` <= `match_cnt` + 1.
  - `expected` <= `expected` + STEP, mod 2^WIDTH. Wrap-around, e.g. 8'hFF to 8'h00, is a match.
  - If the incremented `match_cnt` == PASS_COUNT, next state is `PASS`.
- **TRACK**, on `obs_valid` with `obs_value` != `expected`: next state is `FAIL`. `match_cnt` holds its value.
- Any state, `obs_valid` low: no change to `expected`, `match_cnt` or state, apart from the timeout.
- **PASS** and **FAIL** are terminal. All further samples are ignored until reset.
- `passed` = (state == `PASS`) and `failed` = (state == `FAIL`), both registered. They are never high together.
- `cyc_cnt` increments every cycle while `reset_n` is high and saturates at 16'hFFFF. It keeps counting in the terminal states.
- `obs_value` is ignored entirely while `obs_valid` is low. X on `obs_value` in that case must not propagate.

## Timing
- `passed`/`failed` assert on the clock edge that samples the deciding `obs_valid`, i.e. they are visible one cycle after the deciding sample is presented.
- Minimum time to pass: PASS_COUNT valid cycles. The first `obs_valid` at cycle k gives `passed` high at cycle k+PASS_COUNT.
- Timeout fires when `cyc_cnt` == MAX_CYCLES and the state is `IDLE` or `TRACK`: next state is `FAIL`, and `failed` is high the following cycle.
- Decision and timeout in the same cycle: the sample decision wins. A pass on that cycle is not overridden.
- Asserting `reset_n` at any time, including mid-`TRACK` or in a terminal state, clears every output immediately (asynchronously).
- After reset release, the first edge with `obs_valid` high is treated as the `IDLE` capture.

## Configuration
- Macro: `SIM_RESULT_MONITOR_TIMEOUT_EN`.
- Defined: the MAX_CYCLES timeout into `FAIL` is active as described above.
- Undefined:
  - No timeout logic is present.
  - `failed` asserts only on a mismatch.
  - `cyc_cnt` still counts and saturates.
  - The testbench's own cycle limit is the only bound on run length.

## Structure
- A shared package `sim_result_pkg` holds:
  - The state enum `sim_result_state_e` (`IDLE`, `TRACK`, `PASS`, `FAIL`).
  - The constants `CYC_CNT_W` = 16 and `CYC_CNT_MAX` = 16'hFFFF.
- Sub-module `sat_counter`: a parameterised saturating up-counter with enable and async active-low reset. It is instantiated for both `cyc_cnt` and `match_cnt`.
- Everything else stays in one module.

## Test plan
All scenarios use WIDTH=8, STEP=1, PASS_COUNT=16, MAX_CYCLES=100, timeout enabled unless stated otherwise.
- Clean count: samples 0..15 on consecutive cycles -> `passed` = 1 one cycle after sample 15, `failed` = 0, `match_cnt` = 16.
- Wrap-around: samples 8'hF8..8'hFF then 8'h00..8'h07 -> `passed` = 1, no failure at the wrap.
- Mismatch: 0,1,2,3 then 5 -> `failed` = 1 one cycle after the 5. Later correct samples leave `passed` = 0.
- Gapped valid and timeout: one sample every 10 cycles -> `failed` = 1 at `cyc_cnt` = 101. Repeat without `SIM_RESULT_MONITOR_TIMEOUT_EN` -> no failure, and `passed` at about 160 cycles.
- Same-cycle decision and timeout: the 16th matching sample lands on `cyc_cnt` == 100 -> `passed` = 1, `failed` = 0.
- Reset mid-`TRACK`: drop `reset_n` after 7 matches -> all outputs 0 immediately. Restart at value 42 -> a fresh pass after 16 samples.
